// File: rtl/aes256_inv_round_ctrl.sv
// Sequencing controller for an iterative AES inverse cipher. It walks the round
// keys NUM_ROUNDS..0 through an external combinational inverse-round datapath.
module aes256_inv_round_ctrl #(
    parameter int NUM_ROUNDS = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_data,
    output logic [3:0]   key_index,
    input  logic         key_valid,
    input  logic [0:127] key_in,
    output logic [0:127] state_out,
    output logic         last_round,
    input  logic [0:127] round_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_data,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_INIT  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } fsm_e;

    localparam logic [3:0]   FIRST_KEY  = 4'(NUM_ROUNDS);
    localparam logic [3:0]   FIRST_RND  = 4'(NUM_ROUNDS - 1);
    localparam logic [0:127] ZERO_BLOCK = {128{1'b0}};

    fsm_e         fsm_r, fsm_nxt_s;
    logic [3:0]   rnd_r, rnd_nxt_s;
    logic [0:127] data_r, data_nxt_s;
    logic [3:0]   key_index_r, key_index_nxt_s;
    logic         last_round_r, last_round_nxt_s;
    logic         in_ready_s, busy_s, out_valid_s;

    // State register: FSM, round counter, data block and key-request outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_r        <= S_IDLE;
            rnd_r        <= 4'd0;
            data_r       <= ZERO_BLOCK;
            key_index_r  <= 4'd0;
            last_round_r <= 1'b0;
        end else begin
            fsm_r        <= fsm_nxt_s;
            rnd_r        <= rnd_nxt_s;
            data_r       <= data_nxt_s;
            key_index_r  <= key_index_nxt_s;
            last_round_r <= last_round_nxt_s;
        end
    end

    // Next-state logic; an absent key simply holds every register (stall).
    always_comb begin
        fsm_nxt_s        = fsm_r;
        rnd_nxt_s        = rnd_r;
        data_nxt_s       = data_r;
        key_index_nxt_s  = key_index_r;
        last_round_nxt_s = last_round_r;
        case (fsm_r)
            S_IDLE: begin
                if (in_valid) begin
                    data_nxt_s       = in_data;
                    key_index_nxt_s  = FIRST_KEY;
                    last_round_nxt_s = 1'b0;
                    fsm_nxt_s        = S_INIT;
                end else begin
                    fsm_nxt_s = S_IDLE;
                end
            end
            S_INIT: begin
                if (key_valid) begin
                    data_nxt_s       = data_r ^ key_in;
                    rnd_nxt_s        = FIRST_RND;
                    key_index_nxt_s  = FIRST_RND;
                    last_round_nxt_s = (FIRST_RND == 4'd0);
                    fsm_nxt_s        = S_ROUND;
                end else begin
                    fsm_nxt_s = S_INIT;
                end
            end
            S_ROUND: begin
                if (key_valid) begin
                    data_nxt_s = round_result;
                    // The counter stops at zero; the final round leaves for DONE.
                    if (rnd_r == 4'd0) begin
                        last_round_nxt_s = 1'b0;
                        fsm_nxt_s        = S_DONE;
                    end else begin
                        rnd_nxt_s        = rnd_r - 4'd1;
                        key_index_nxt_s  = rnd_r - 4'd1;
                        last_round_nxt_s = (rnd_r == 4'd1);
                    end
                end else begin
                    fsm_nxt_s = S_ROUND;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    fsm_nxt_s = S_IDLE;
                end else begin
                    fsm_nxt_s = S_DONE;
                end
            end
            default: begin
                fsm_nxt_s        = S_IDLE;
                last_round_nxt_s = 1'b0;
            end
        endcase
    end

    // Handshake and status outputs decoded from the registered FSM state only.
    always_comb begin
        in_ready_s  = 1'b0;
        busy_s      = 1'b1;
        out_valid_s = 1'b0;
        case (fsm_r)
            S_IDLE: begin
                in_ready_s = 1'b1;
                busy_s     = 1'b0;
            end
            S_INIT, S_ROUND: begin
                busy_s = 1'b1;
            end
            S_DONE: begin
                out_valid_s = 1'b1;
            end
            default: begin
                in_ready_s  = 1'b0;
                busy_s      = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    assign in_ready   = in_ready_s;
    assign busy       = busy_s;
    assign out_valid  = out_valid_s;
    assign key_index  = key_index_r;
    assign last_round = last_round_r;
    assign state_out  = data_r;
    assign out_data   = data_r;

endmodule
